// File: rtl/debounce_pkg.sv
// Shared defaults, repeat-state encoding and counter sizing for debounce_array.
package debounce_pkg;

  localparam int unsigned DEF_CHANNELS     = 5;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_CNT_WIDTH    = 20;
  localparam int unsigned DEF_STABLE_COUNT = 100000;
  localparam int unsigned DEF_HOLD_COUNT   = 50000000;
  localparam int unsigned DEF_REPEAT_COUNT = 10000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Bits needed to hold any value in 0..max_val (at least 1).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((max_val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability filter, edge pulses and,
// with DEBOUNCE_REPEAT_EN defined, a hold-to-repeat state machine.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned HOLD_COUNT   = DEF_HOLD_COUNT,
  parameter int unsigned REPEAT_COUNT = DEF_REPEAT_COUNT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam int unsigned HOLD_W =
    cnt_bits((HOLD_COUNT > REPEAT_COUNT ? HOLD_COUNT : REPEAT_COUNT) - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == STABLE_LAST) begin
      cnt_d  = '0;
      out_d  = sync;
      rise_d = sync;
      fall_d = ~sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = out_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_COUNT - 1);
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_COUNT - 1);

  rpt_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              rpt_q;

  // Keyed off next-cycle level/rise so the hold count starts on the btn_rise
  // cycle and a repeat landing on the btn_fall cycle is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rpt_q   <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      if (!out_d) begin
        state_q <= IDLE;
        hold_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise_d) begin
              state_q <= HOLD;
              hold_q  <= '0;
            end
          end
          HOLD: begin
            if (hold_q == HOLD_LAST) begin
              state_q <= REPEAT;
              hold_q  <= '0;
              rpt_q   <= 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          REPEAT: begin
            if (hold_q == REPEAT_LAST) begin
              hold_q <= '0;
              rpt_q  <= 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            hold_q  <= '0;
          end
        endcase
      end
    end
  end

  assign repeat_o = rpt_q;
`else
  logic [HOLD_W-1:0] unused_hold;
  assign unused_hold = '0;
  assign repeat_o    = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// Multi-channel push-button debouncer; repeat pulses are built only when
// DEBOUNCE_REPEAT_EN is defined, otherwise btn_repeat is tied low.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = DEF_CHANNELS,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int unsigned HOLD_COUNT   = DEF_HOLD_COUNT,
  parameter int unsigned REPEAT_COUNT = DEF_REPEAT_COUNT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_out,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_repeat
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH),
      .STABLE_COUNT(STABLE_COUNT),
      .HOLD_COUNT  (HOLD_COUNT),
      .REPEAT_COUNT(REPEAT_COUNT)
    ) u_ch (
      .clk_i   (clock),
      .rst_ni  (reset_n),
      .btn_i   (btn_in[g]),
      .level_o (btn_out[g]),
      .rise_o  (btn_rise[g]),
      .fall_o  (btn_fall[g]),
      .repeat_o(btn_repeat[g])
    );
  end

endmodule
